// File: rtl/register_w4_rst_en_pkg.sv
// Shared constants for the holding-register slice.
//   DEFAULT_WIDTH : default data width of register_w4_rst_en
package register_w4_rst_en_pkg;

   localparam int DEFAULT_WIDTH = 4;

endpackage : register_w4_rst_en_pkg

// File: rtl/register_w4_rst_en.sv
// Generic load-enabled holding register with synchronous reset.
// Captures data_in on a rising clk edge when en is high and holds it
// otherwise. loaded flags that at least one load happened since reset.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous reset, active HIGH despite the name (kept so
//              existing instantiations keep connecting by name)
//   en       : load enable, active high
//   data_in  : value to capture, WIDTH bits
//   data_out : registered value, WIDTH bits
//   loaded   : high once an enabled load has occurred since last reset
module register_w4_rst_en
   import register_w4_rst_en_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             loaded
);

   // Reset has priority over the load enable.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         data_out <= RST_VAL;
         loaded   <= 1'b0;
      end else if (en) begin
         data_out <= data_in;
         loaded   <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_width_legal : assert property (@(posedge clk) WIDTH >= 1)
      else $error("register_w4_rst_en: WIDTH must be >= 1");

   a_reset_val : assert property (@(posedge clk) rst_n |=> (data_out == RST_VAL))
      else $error("register_w4_rst_en: data_out not RST_VAL after reset");

   a_load : assert property (@(posedge clk)
      (!rst_n && en) |=> (data_out == $past(data_in)))
      else $error("register_w4_rst_en: load did not capture data_in");

   a_hold : assert property (@(posedge clk)
      (!rst_n && !en) |=> (data_out == $past(data_out)))
      else $error("register_w4_rst_en: data_out changed while idle");

   a_no_x : assert property (@(posedge clk) loaded |-> !$isunknown(data_out))
      else $error("register_w4_rst_en: X on data_out after load");
`endif

endmodule : register_w4_rst_en

// File: tb/tb_register_w4_rst_en.sv
module tb_register_w4_rst_en;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  d4;
   logic [3:0]  q4;
   logic        l4;
   logic [0:0]  d1;
   logic [0:0]  q1;
   logic        l1;
   logic [15:0] d16;
   logic [15:0] q16;
   logic        l16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   register_w4_rst_en u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .data_in(d4), .data_out(q4), .loaded(l4)
   );

   register_w4_rst_en #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .data_in(d1), .data_out(q1), .loaded(l1)
   );

   register_w4_rst_en #(.WIDTH(16), .RST_VAL(16'h5A5A)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .data_in(d16), .data_out(q16), .loaded(l16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      d4    = 4'hF;
      d1    = 1'b1;
      d16   = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         en = i[0];
         tick();
         n_cmp++;
         if (q4 !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_data cyc=%0d got=%h exp=0", i, q4);
         end
         n_cmp++;
         if (l4 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_loaded cyc=%0d got=%b exp=0", i, l4);
         end
      end
      n_cmp++;
      if (q16 !== 16'h5A5A) begin
         n_bad++;
         $display("FAIL reset_val16 got=%h exp=5a5a", q16);
      end
      n_cmp++;
      if (q1 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_val1 got=%b exp=0", q1);
      end
   endtask

   task automatic test_load();
      rst_n = 1'b0;
      en    = 1'b1;
      d4    = 4'h5;
      tick();
      n_cmp++;
      if (q4 !== 4'h5) begin
         n_bad++;
         $display("FAIL load_5 got=%h exp=5", q4);
      end
      n_cmp++;
      if (l4 !== 1'b1) begin
         n_bad++;
         $display("FAIL load_loaded got=%b exp=1", l4);
      end
      d4 = 4'hA;
      tick();
      n_cmp++;
      if (q4 !== 4'hA) begin
         n_bad++;
         $display("FAIL load_A got=%h exp=a", q4);
      end
   endtask

   task automatic test_hold();
      rst_n = 1'b0;
      en    = 1'b0;
      d4    = 4'h3;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (q4 !== 4'hA || l4 !== 1'b1) begin
            n_bad++;
            $display("FAIL hold cyc=%0d got=%h/%b exp=a/1", i, q4, l4);
         end
      end
   endtask

   task automatic test_reset_over_en();
      rst_n = 1'b1;
      en    = 1'b1;
      d4    = 4'h7;
      tick();
      n_cmp++;
      if (q4 !== 4'h0 || l4 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_over_en got=%h/%b exp=0/0", q4, l4);
      end
      rst_n = 1'b0;
      en    = 1'b0;
      tick();
      n_cmp++;
      if (q4 !== 4'h0 || l4 !== 1'b0) begin
         n_bad++;
         $display("FAIL release_idle got=%h/%b exp=0/0", q4, l4);
      end
   endtask

   task automatic test_mid_cycle();
      // Called at posedge+1; next edge is 9 time units away.
      rst_n = 1'b0;
      en    = 1'b1;
      d4    = 4'h1;
      #2;
      d4 = 4'h2;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_bad++;
         $display("FAIL mid_cycle_early got=%h exp=0", q4);
      end
      #2;
      d4 = 4'h6;
      #2;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_bad++;
         $display("FAIL mid_cycle_late got=%h exp=0", q4);
      end
      tick();
      n_cmp++;
      if (q4 !== 4'h6 || l4 !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_cycle_capture got=%h/%b exp=6/1", q4, l4);
      end
   endtask

   task automatic test_random();
      logic [3:0]  m4;
      logic [0:0]  m1;
      logic [15:0] m16;
      logic        ml;
      for (int i = 0; i < 1000; i++) begin
         rst_n = (i == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
         en    = $urandom_range(0, 1) == 1;
         d4    = 4'($urandom);
         d1    = 1'($urandom);
         d16   = 16'($urandom);
         if (rst_n) begin
            m4  = 4'h0;
            m1  = 1'b0;
            m16 = 16'h5A5A;
            ml  = 1'b0;
         end else if (en) begin
            m4  = d4;
            m1  = d1;
            m16 = d16;
            ml  = 1'b1;
         end
         tick();
         n_cmp++;
         if (q4 !== m4 || l4 !== ml) begin
            n_bad++;
            $display("FAIL rand_w4 cyc=%0d got=%h/%b exp=%h/%b", i, q4, l4, m4, ml);
         end
         n_cmp++;
         if (q1 !== m1 || l1 !== ml) begin
            n_bad++;
            $display("FAIL rand_w1 cyc=%0d got=%b/%b exp=%b/%b", i, q1, l1, m1, ml);
         end
         n_cmp++;
         if (q16 !== m16 || l16 !== ml) begin
            n_bad++;
            $display("FAIL rand_w16 cyc=%0d got=%h/%b exp=%h/%b", i, q16, l16, m16, ml);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      d4    = '0;
      d1    = '0;
      d16   = '0;
      test_reset();
      test_load();
      test_hold();
      test_reset_over_en();
      test_mid_cycle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_register_w4_rst_en

// File: doc/register_w4_rst_en.md
Name: register_w4_rst_en

Overview:
Parameterised-width data register, default 4 bits, with synchronous reset and a load-enable. It is a generic pipeline/holding element used wherever a value must be captured on demand and held between loads. A single clock domain and no combinational path from inputs to outputs.

Parameters:
WIDTH, 4, data bit width (legal range 1..64).
RST_VAL, {WIDTH{1'b0}}, value loaded into data_out while reset is asserted.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-HIGH. Asserted when 1; the name is kept for interface compatibility with existing instantiations.
en  input  1  load enable, active-high.
data_in  input  WIDTH  value to capture.
data_out  output  WIDTH  registered value.
loaded  output  1  high once at least one enabled load has occurred since the last reset.

Behaviour:
- All state updates occur on the rising edge of clk only. There are no asynchronous paths.
- Priority at each rising edge:
  1. If rst_n == 1: data_out <= RST_VAL and loaded <= 0.
  2. Else if en == 1: data_out <= data_in and loaded <= 1.
  3. Else: data_out and loaded hold their values.
- Reset overrides en. If rst_n == 1 and en == 1 on the same edge, data_out = RST_VAL.
- Latency: data_in sampled at edge N appears on data_out immediately after edge N (1-cycle latency). data_out is a pure flop output with no glitching.
- en or data_in changes between edges have no effect until the next edge.
- Reset mid-operation: the next edge after rst_n rises clears data_out and loaded, regardless of en and prior contents.
- Power-up before the first reset edge: outputs are undefined (X in simulation). No initial value is relied upon.
- Width: data_in maps bit-for-bit to data_out, with no sign or extension logic.
- Both outputs are driven from flops. There is no combinational input-to-output path.
- Embedded assertions (simulation only, guarded by a macro):
  - Parameter check: WIDTH >= 1.
  - One edge after rst_n is high, data_out == RST_VAL.
  - One edge after a load with rst_n == 0 and en == 1, data_out equals the sampled data_in.
  - One edge after rst_n == 0 and en == 0, data_out is unchanged.
  - No X on data_out once loaded == 1.

Decomposition:
- No shared package required. The default WIDTH constant may live in the project's common constants package if one exists.
- No sub-module. The block is a single flat always_ff process plus assertions.

Test Plan:
1. rst_n = 1 for 10 cycles while en toggles and data_in = 4'hF -> data_out == 4'h0 and loaded == 0 on every edge.
2. rst_n = 0, en = 1, data_in = 4'h5 -> after the next edge data_out == 4'h5, loaded == 1. Then data_in = 4'hA -> next edge data_out == 4'hA.
3. rst_n = 0, en = 0, data_in = 4'h3 for 10 cycles after holding 4'hA -> data_out stays 4'hA and loaded stays 1.
4. While holding 4'hA, assert rst_n = 1 with en = 1 and data_in = 4'h7 for one edge -> data_out == 4'h0 and loaded == 0. Release with en = 0 -> data_out remains 4'h0.
5. data_in changes mid-cycle (between edges) with en = 1 -> data_out takes only the value present at the rising edge, with no intermediate transitions.
6. Random regression: 1000 cycles of random rst_n, en and data_in compared against a reference model; repeat with WIDTH = 1 and WIDTH = 16 and a non-zero RST_VAL (e.g. 'h5A5A).
